// File: rtl/fetch_pc_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit_pkg
// Description : Shared constants for the fetch-stage PC generator. Holds the
//               next-PC select codes, the default memory-map vectors, the
//               fetch address exception code and the branch offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_unit_pkg;

  // Next-PC select codes driven by D-stage control
  typedef enum logic [2:0] {
    NPC_PC4    = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JR     = 3'd3
  } npc_sel_e;

  // Default memory map
  localparam logic [31:0] C_DEF_RESET_VEC   = 32'h0000_3000;
  localparam logic [31:0] C_DEF_HANDLER_VEC = 32'h0000_4180;
  localparam logic [31:0] C_DEF_IM_BASE     = 32'h0000_3000;
  localparam logic [31:0] C_DEF_IM_LIMIT    = 32'h0000_6FFF;

  // CP0 exception code reported for a bad fetch address
  localparam logic [4:0]  C_EXC_ADEL        = 5'd4;

  // Sign-extended word offset of a branch immediate
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage : fetch_pc_unit_pkg
`default_nettype wire

// File: rtl/fetch_pc_unit_npc_select.sv
`default_nettype none
// ============================================================================
// Module      : npc_select
// Description : Stateless next-PC target mux. Picks between sequential,
//               branch, jump and register-indirect targets; unknown select
//               codes fall back to the reset vector.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_select
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = C_DEF_RESET_VEC,
  parameter int          NPC_SEL_W = 3
) (
  input  logic [NPC_SEL_W-1:0] nPC_Sel,
  input  logic [31:0]          F_PC,
  input  logic                 D_bjump,
  input  logic [31:0]          D_PC,
  input  logic [15:0]          D_imm16,
  input  logic [25:0]          D_imm26,
  input  logic [31:0]          D_ra,
  output logic [31:0]          o_target
);

  logic [31:0] w_d_pc4;

  assign w_d_pc4 = D_PC + 32'd4;

  // Target selection; all adds wrap modulo 2^32
  always_comb begin
    o_target = RESET_VEC;
    case (nPC_Sel)
      NPC_SEL_W'(NPC_PC4):    o_target = F_PC + 32'd4;
      NPC_SEL_W'(NPC_BRANCH): o_target = D_bjump ? (w_d_pc4 + branch_offset(D_imm16)) : w_d_pc4;
      NPC_SEL_W'(NPC_JUMP):   o_target = {D_PC[31:28], D_imm26, 2'b00};
      NPC_SEL_W'(NPC_JR):     o_target = D_ra;
      default:                o_target = RESET_VEC;
    endcase
  end

endmodule : npc_select
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : F-stage PC register with stall hold, exception entry, eret
//               return and fetch address error detection.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC   = C_DEF_RESET_VEC,
  parameter logic [31:0] HANDLER_VEC = C_DEF_HANDLER_VEC,
  parameter logic [31:0] IM_BASE     = C_DEF_IM_BASE,
  parameter logic [31:0] IM_LIMIT    = C_DEF_IM_LIMIT,
  parameter int          NPC_SEL_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NPC_SEL_W-1:0] nPC_Sel,
  input  logic                 D_bjump,
  input  logic [31:0]          D_PC,
  input  logic [15:0]          D_imm16,
  input  logic [25:0]          D_imm26,
  input  logic [31:0]          D_ra,
  input  logic                 Req,
  input  logic                 eret,
  input  logic [31:0]          EPC,
  output logic [31:0]          F_PC,
  output logic [31:0]          NPC,
  output logic                 F_ExcAdEL
);

  logic [31:0] r_pc;
  logic [31:0] w_target;
  logic [31:0] w_npc;

  npc_select #(
    .RESET_VEC (RESET_VEC),
    .NPC_SEL_W (NPC_SEL_W)
  ) u_npc_select (
    .nPC_Sel  (nPC_Sel),
    .F_PC     (r_pc),
    .D_bjump  (D_bjump),
    .D_PC     (D_PC),
    .D_imm16  (D_imm16),
    .D_imm26  (D_imm26),
    .D_ra     (D_ra),
    .o_target (w_target)
  );

  // Redirect priority: exception entry beats eret, both beat the normal target
  always_comb begin
    w_npc = w_target;
    if (Req)       w_npc = HANDLER_VEC;
    else if (eret) w_npc = EPC;
  end

  // PC register; Req and eret redirect even through a stall
  always_ff @(posedge clk) begin
    if (reset)                   r_pc <= RESET_VEC;
    else if (Req || eret || en)  r_pc <= w_npc;
  end

  assign F_PC      = r_pc;
  assign NPC       = w_npc;
  assign F_ExcAdEL = (r_pc[1:0] != 2'b00) | (r_pc < IM_BASE) | (r_pc > IM_LIMIT);

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Self-checking bench for fetch_pc_unit with a reference model
//               feeding an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  localparam logic [31:0] C_RESET   = 32'h0000_3000;
  localparam logic [31:0] C_HANDLER = 32'h0000_4180;
  localparam logic [31:0] C_BASE    = 32'h0000_3000;
  localparam logic [31:0] C_LIMIT   = 32'h0000_6FFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [2:0]  nPC_Sel = 3'd0;
  logic        D_bjump = 1'b0;
  logic [31:0] D_PC = 32'h0;
  logic [15:0] D_imm16 = 16'h0;
  logic [25:0] D_imm26 = 26'h0;
  logic [31:0] D_ra = 32'h0;
  logic        Req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] EPC = 32'h0;
  logic [31:0] F_PC;
  logic [31:0] NPC;
  logic        F_ExcAdEL;

  fetch_pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .nPC_Sel   (nPC_Sel),
    .D_bjump   (D_bjump),
    .D_PC      (D_PC),
    .D_imm16   (D_imm16),
    .D_imm26   (D_imm26),
    .D_ra      (D_ra),
    .Req       (Req),
    .eret      (eret),
    .EPC       (EPC),
    .F_PC      (F_PC),
    .NPC       (NPC),
    .F_ExcAdEL (F_ExcAdEL)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [2:0]  sel;
    logic        bj;
    logic [31:0] dpc;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] ra;
    logic        req;
    logic        eret;
    logic [31:0] epc;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        adel;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_pc;
  int          n_vec  = 0;
  int          n_fail = 0;

  function automatic logic model_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < C_BASE) || (pc > C_LIMIT);
  endfunction

  function automatic logic [31:0] model_target(input stim_t s, input logic [31:0] pc);
    logic [31:0] off;
    off = {{14{s.i16[15]}}, s.i16, 2'b00};
    case (s.sel)
      3'd0:    return pc + 32'd4;
      3'd1:    return s.bj ? s.dpc + 32'd4 + off : s.dpc + 32'd4;
      3'd2:    return {s.dpc[31:28], s.i26, 2'b00};
      3'd3:    return s.ra;
      default: return C_RESET;
    endcase
  endfunction

  // Drive one cycle of stimulus, update the model, queue the expected PC
  task automatic apply(input stim_t s, output logic [31:0] exp_npc);
    exp_t e;
    reset = s.rst; en = s.en; nPC_Sel = s.sel; D_bjump = s.bj; D_PC = s.dpc;
    D_imm16 = s.i16; D_imm26 = s.i26; D_ra = s.ra; Req = s.req; eret = s.eret; EPC = s.epc;
    exp_npc = s.req ? C_HANDLER : (s.eret ? s.epc : model_target(s, m_pc));
    if (s.rst)                         m_pc = C_RESET;
    else if (s.req || s.eret || s.en)  m_pc = exp_npc;
    e.pc = m_pc;
    e.adel = model_adel(m_pc);
    q.push_back(e);
  endtask

  function automatic stim_t mk(input logic rst, input logic en_i, input logic [2:0] sel,
                               input logic bj, input logic [31:0] dpc, input logic [15:0] i16,
                               input logic [25:0] i26, input logic [31:0] ra, input logic req,
                               input logic er, input logic [31:0] epc);
    stim_t s;
    s.rst = rst; s.en = en_i; s.sel = sel; s.bj = bj; s.dpc = dpc; s.i16 = i16;
    s.i26 = i26; s.ra = ra; s.req = req; s.eret = er; s.epc = epc;
    return s;
  endfunction

  task automatic test_reset();
    stim_t       s[5];
    logic [31:0] en_npc;
    exp_t        e;
    s[0] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s[1] = mk(1, 0, 3, 0, 0, 0, 0, 32'h7000, 0, 1, 32'h5000);
    for (int i = 2; i < 5; i++) s[i] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(s[i], en_npc);
      #1;
      if (!s[i].rst) begin
        n_vec++;
        if (NPC !== en_npc) begin
          n_fail++;
          $display("FAIL reset_npc[%0d]: got %h expected %h", i, NPC, en_npc);
        end
      end
      @(posedge clk); #1;
      e = q.pop_front();
      n_vec++;
      if (F_PC !== e.pc || F_ExcAdEL !== e.adel) begin
        n_fail++;
        $display("FAIL reset_seq[%0d]: got pc=%h adel=%b expected pc=%h adel=%b", i, F_PC, F_ExcAdEL, e.pc, e.adel);
      end
    end
  endtask

  task automatic test_branch_jump();
    stim_t       s[8];
    logic [31:0] en_npc;
    exp_t        e;
    s[0] = mk(0, 1, 1, 1, 32'h3010, 16'hFFFC, 0, 0, 0, 0, 0);
    s[1] = mk(0, 1, 1, 0, 32'h3010, 16'hFFFC, 0, 0, 0, 0, 0);
    s[2] = mk(0, 1, 1, 1, 32'h3010, 16'h0010, 0, 0, 0, 0, 0);
    s[3] = mk(0, 1, 2, 0, 32'h3020, 0, 26'h0000C10, 0, 0, 0, 0);
    s[4] = mk(0, 1, 3, 0, 0, 0, 0, 32'h3002, 0, 0, 0);
    s[5] = mk(0, 1, 3, 0, 0, 0, 0, 32'h2FFC, 0, 0, 0);
    s[6] = mk(0, 1, 3, 0, 0, 0, 0, 32'h6FFC, 0, 0, 0);
    s[7] = mk(0, 1, 5, 0, 32'h3020, 0, 26'h0000C10, 32'h5000, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      apply(s[i], en_npc);
      #1;
      n_vec++;
      if (NPC !== en_npc) begin
        n_fail++;
        $display("FAIL target_npc[%0d]: got %h expected %h", i, NPC, en_npc);
      end
      @(posedge clk); #1;
      e = q.pop_front();
      n_vec++;
      if (F_PC !== e.pc || F_ExcAdEL !== e.adel) begin
        n_fail++;
        $display("FAIL target_pc[%0d]: got pc=%h adel=%b expected pc=%h adel=%b", i, F_PC, F_ExcAdEL, e.pc, e.adel);
      end
    end
  endtask

  task automatic test_stall_exc();
    stim_t       s[11];
    logic [31:0] en_npc;
    exp_t        e;
    s[0]  = mk(0, 1, 3, 0, 0, 0, 0, 32'h3008, 0, 0, 0);
    s[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s[2]  = mk(0, 0, 3, 0, 0, 0, 0, 32'h5000, 0, 0, 0);
    s[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    s[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3100);
    s[5]  = mk(0, 1, 2, 0, 32'h3020, 0, 26'h0000C10, 0, 1, 1, 32'h3100);
    s[6]  = mk(0, 1, 3, 0, 0, 0, 0, 32'h7000, 0, 0, 0);
    s[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    s[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s[10] = mk(0, 1, 1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      apply(s[i], en_npc);
      #1;
      n_vec++;
      if (NPC !== en_npc) begin
        n_fail++;
        $display("FAIL ctrl_npc[%0d]: got %h expected %h", i, NPC, en_npc);
      end
      @(posedge clk); #1;
      e = q.pop_front();
      n_vec++;
      if (F_PC !== e.pc || F_ExcAdEL !== e.adel) begin
        n_fail++;
        $display("FAIL ctrl_pc[%0d]: got pc=%h adel=%b expected pc=%h adel=%b", i, F_PC, F_ExcAdEL, e.pc, e.adel);
      end
    end
  endtask

  task automatic test_reset_priority();
    stim_t       s;
    logic [31:0] en_npc;
    exp_t        e;
    s = mk(1, 0, 3, 0, 0, 0, 0, 32'h7001, 1, 1, 32'h7002);
    apply(s, en_npc);
    @(posedge clk); #1;
    e = q.pop_front();
    n_vec++;
    if (F_PC !== e.pc || F_ExcAdEL !== e.adel) begin
      n_fail++;
      $display("FAIL reset_prio: got pc=%h adel=%b expected pc=%h adel=%b", F_PC, F_ExcAdEL, e.pc, e.adel);
    end
  endtask

  task automatic test_back_to_back();
    stim_t       s;
    logic [31:0] en_npc;
    exp_t        e;
    for (int i = 0; i < 40; i++) begin
      s = mk(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
             3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
             32'h3000 + {18'h0, 12'($urandom_range(0, 4095)), 2'b00}, 16'($urandom),
             26'($urandom), 32'h2FF0 + 32'($urandom_range(0, 32)),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             32'h3000 + 32'($urandom_range(0, 64)));
      apply(s, en_npc);
      #1;
      if (!s.rst) begin
        n_vec++;
        if (NPC !== en_npc) begin
          n_fail++;
          $display("FAIL b2b_npc[%0d]: got %h expected %h", i, NPC, en_npc);
        end
      end
      @(posedge clk); #1;
      e = q.pop_front();
      n_vec++;
      if (F_PC !== e.pc || F_ExcAdEL !== e.adel) begin
        n_fail++;
        $display("FAIL b2b_pc[%0d]: got pc=%h adel=%b expected pc=%h adel=%b", i, F_PC, F_ExcAdEL, e.pc, e.adel);
      end
    end
  endtask

  initial begin
    m_pc = C_RESET;
    test_reset();
    test_branch_jump();
    test_stall_exc();
    test_reset_priority();
    test_back_to_back();
    test_reset_priority();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d leftover entries expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_fetch_pc_unit
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Next-generation fetch-stage PC generator for the pipelined MIPS core. It owns the F-stage PC register and computes the next PC from D-stage branch/jump/jr decisions.
- Adds stall hold, exception entry, eret return and fetch-address exception detection, all parametrised by the memory map.
- Sits between the hazard/CP0 control and the IM; its F_PC output drives IM addressing and the F/D pipeline register.

Parameters:
- RESET_VEC, 32'h0000_3000, PC value loaded on reset.
- HANDLER_VEC, 32'h0000_4180, PC loaded on exception request.
- IM_BASE, 32'h0000_3000, lowest legal fetch address (inclusive).
- IM_LIMIT, 32'h0000_6FFF, highest legal fetch address (inclusive).
- NPC_SEL_W, 3, width of the next-PC select code.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  PC write enable; 0 = stall (hazard unit).
- nPC_Sel  in  NPC_SEL_W  next-PC select: NPC_PC4 / NPC_BRANCH / NPC_JUMP / NPC_JR (shared constants).
- D_bjump  in  1  branch condition true for the D-stage branch.
- D_PC  in  32  PC of the D-stage instruction.
- D_imm16  in  16  branch offset.
- D_imm26  in  26  jump instr_index.
- D_ra  in  32  forwarded rs value for jr/jalr.
- Req  in  1  exception/interrupt request from CP0.
- eret  in  1  eret being executed (D-stage decode).
- EPC  in  32  return address from CP0.
- F_PC  out  32  current fetch PC (registered).
- NPC  out  32  combinational next PC selected this cycle.
- F_ExcAdEL  out  1  fetch address exception flag for the F-stage instruction.

Behaviour:
- Only state is the PC register; F_PC = PC register.
- Reset (sync, on the edge with reset=1): PC <= RESET_VEC, regardless of the other inputs. After reset F_PC=RESET_VEC, F_ExcAdEL=0 (the default RESET_VEC is legal).
- NPC computation (combinational):
  - NPC_PC4: F_PC+4.
  - NPC_BRANCH: D_bjump ? D_PC+4+(sext(D_imm16)<<2) : D_PC+4.
  - NPC_JUMP: {D_PC[31:28], D_imm26, 2'b00}.
  - NPC_JR: D_ra.
  - Any other code: RESET_VEC.
- All arithmetic is modulo 2^32; wrap-around is silent.
- PC update priority each edge:
  - reset > Req > eret > !en > normal.
  - Req=1: PC <= HANDLER_VEC, even when en=0 or eret=1.
  - eret=1 (Req=0): PC <= EPC, ignoring en. No delay slot is fetched after eret.
  - en=0: PC holds.
  - Otherwise: PC <= NPC.
- The NPC output always shows the value PC would take under the active priority, so it equals HANDLER_VEC when Req=1 and EPC when eret=1.
- F_ExcAdEL (combinational from F_PC) = (F_PC[1:0]!=0) | (F_PC<IM_BASE) | (F_PC>IM_LIMIT), using unsigned compares.
- A bad jr target therefore raises F_ExcAdEL one cycle after the redirect, while that PC is in F. The flag stays up while stalled on that PC and clears when Req redirects to HANDLER_VEC.
- Reset asserted mid-stall or coincident with Req/eret: reset wins and no exception state is retained.
- Latency: one cycle from a D-stage decision to F_PC. Branch delay slot semantics are unchanged (the slot is the F instruction on the redirect cycle).

Decomposition:
- Shared constants header: NPC_PC4/NPC_BRANCH/NPC_JUMP/NPC_JR encodings, default vectors, exception code ExcAdEL=4.
- One natural sub-module: npc_select, the combinational target mux with no state. It is instantiated inside fetch_pc_unit; the PC register, priority logic and AdEL check stay in the top.

Test Plan:
- Reset then 3 cycles, en=1, nPC_Sel=PC4 -> F_PC 0x3000, 0x3004, 0x3008, 0x300C; F_ExcAdEL=0.
- D_PC=0x3010, D_imm16=16'hFFFC, D_bjump=1, BRANCH -> next F_PC=0x3004. Same with D_bjump=0 -> 0x3014.
- JUMP with D_PC=0x3020, D_imm26=26'h0000C10 -> F_PC=0x3040. JR with D_ra=0x3002 -> F_PC=0x3002 and F_ExcAdEL=1 that cycle.
- en=0 for 2 cycles at F_PC=0x3008 -> F_PC holds 0x3008. Req=1 during the stall -> F_PC=0x4180 next cycle.
- eret=1, EPC=0x3100, en=0 -> F_PC=0x3100. Req=1 and eret=1 together -> F_PC=0x4180.
- JR with D_ra=0x7000 -> F_ExcAdEL=1. reset=1 with Req=1 on the same edge -> F_PC=0x3000, F_ExcAdEL=0.
